leaf_router_buffered: RTL and testbench
=======================================

Name: leaf_router_buffered

Overview:
- Parametrised next-generation leaf router with buffered ingress.
- Connects one GPU port to NUM_SPINES spine links. Each ingress port has a real FIFO; each egress port has a holding register with valid/ready backpressure.
- Round-robin arbitration for the GPU egress, local/remote routing on a 6-bit destination address, and drop counting for misrouted spine traffic.
- Sits between the GPU endpoint and the spine layer of one group.

Parameters:
- DWIDTH, 16, payload width.
- FIFO_DEPTH, 8, entries per ingress FIFO; power of two, at least 2.
- NUM_SPINES, 4, spine links; one of 1, 2 or 4.
- GROUP_ID, 4'b0001, this router's group; compared against dest[5:2].
- ROUTER_ID, 3, this leaf's index in the group; compared against dest[1:0].

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- arb_enable  in  1  global transfer enable; when 0, nothing moves from a FIFO to an egress register.
- gpu_in_data  in  DWIDTH  GPU ingress payload.
- gpu_in_valid  in  1  GPU ingress valid.
- gpu_in_ready  out  1  equals !gpu_fifo_in_full.
- gpu_dest_addr  in  6  GPU ingress destination.
- gpu_out_data  out  DWIDTH  GPU egress payload.
- gpu_out_valid  out  1  GPU egress valid.
- gpu_out_ready  in  1  GPU egress ready.
- spine_in_data  in  NUM_SPINES*DWIDTH  spine ingress payloads; spine i occupies bits [i*DWIDTH +: DWIDTH].
- spine_in_valid  in  NUM_SPINES  spine ingress valids.
- spine_in_ready  out  NUM_SPINES  per-spine !full.
- spine_dest_addr  in  NUM_SPINES*6  spine ingress destinations.
- spine_out_data  out  NUM_SPINES*DWIDTH  spine egress payloads.
- spine_out_valid  out  NUM_SPINES  spine egress valids.
- spine_out_ready  in  NUM_SPINES  spine egress readies.
- spine_fifo_in_full  out  NUM_SPINES  ingress FIFO full flags.
- spine_fifo_in_empty  out  NUM_SPINES  ingress FIFO empty flags.
- gpu_fifo_in_full  out  1  GPU ingress FIFO full.
- gpu_fifo_in_empty  out  1  GPU ingress FIFO empty.
- crossbar_busy  out  1  activity flag.
- current_grant  out  3  last GPU-egress winner.
- routing_direction  out  2  transfers in the current cycle.
- drop_count  out  8  saturating count of dropped spine packets.

Behaviour:
- Reset (synchronous):
  - All FIFOs empty.
  - All *_out_valid = 0; *_out_data = 0.
  - Round-robin pointer = 0; current_grant = 0; routing_direction = 00; drop_count = 0.
  - After reset, in_ready = 1 on every port.
  - Reset asserted mid-operation discards all buffered packets with no partial output.
- Ingress:
  - A packet (data plus dest) is pushed when valid && ready.
  - A full FIFO refuses the push even if a pop happens in the same cycle.
  - There is no empty-FIFO bypass: a pushed entry becomes the head on the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Local packet: dest[5:2] == GROUP_ID and dest[1:0] == ROUTER_ID.
- GPU FIFO head:
  - If local, it requests the GPU egress as requester 0 (loopback).
  - Otherwise it targets spine index dest[S-1:0], where S = log2(NUM_SPINES); with NUM_SPINES = 1 it always targets spine 0.
  - Only the GPU FIFO feeds spine egresses, so no arbitration is needed there.
- Spine i FIFO head:
  - If local, it requests the GPU egress as requester i+1.
  - If not local, it is popped and discarded on any arb_enable cycle, and drop_count increments, saturating at 255.
- Egress register availability: the register is free when !out_valid, or when out_valid && out_ready in the same cycle (full-throughput draining).
- GPU egress arbitration:
  - Round-robin over requesters 0..NUM_SPINES, searching upward from the pointer.
  - On a grant: the head is popped, the register is loaded, current_grant = winner, and the pointer becomes winner+1, wrapping to 0 after NUM_SPINES.
  - No grant leaves the pointer unchanged.
- Transfer condition: a transfer occurs only when arb_enable = 1 and the target register is free. At most one transfer into each egress per cycle.
- Latency and hold:
  - A packet accepted at edge E is loaded into its egress at edge E+1 at the earliest, with out_valid high after edge E+1.
  - out_data is held stable while out_valid && !out_ready.
- routing_direction (registered, reflects transfers made at the last edge):
  - 01 = GPU FIFO to a spine.
  - 10 = any spine (or loopback) to GPU.
  - 11 = both.
  - 00 = none.
- crossbar_busy (combinational) = any ingress FIFO non-empty OR any out_valid.
- arb_enable = 0: FIFOs keep accepting until full; egress registers still drain.

Test Plan:
- GPU push data 16'hA5A5, dest {GROUP_ID, 2'd3} → gpu_out_valid after 2 edges with 16'hA5A5; routing_direction = 10; current_grant = 0.
- GPU push dest 6'b1000_01 with NUM_SPINES = 4 → spine_out_valid[1] = 1 with the payload; other spine valids 0; routing_direction = 01.
- Spines 0–3 push local packets in the same cycle with gpu_out_ready = 1 → delivered in order spine0..spine3 on consecutive cycles; current_grant sequence 1, 2, 3, 4; pointer wraps to 0.
- gpu_out_ready = 0, GPU pushes 10 local packets → gpu_in_ready falls after 8 accepted plus 1 held in the egress register (9 total); data held stable; after ready = 1 all 9 drain in order.
- Spine 2 pushes dest {4'b0010, 2'd0} three times → no GPU output; drop_count = 3; 300 such pushes → drop_count saturates at 255.
- Fill the GPU FIFO to 5 entries, assert reset for 1 cycle → all valids 0, gpu_fifo_in_empty = 1, drop_count = 0, no stale output afterwards.

Source files
------------

// File: rtl/leaf_router_buffered.sv
// Leaf router with buffered ingress: one GPU port and NUM_SPINES spine links, each ingress
// FIFO-backed, each egress a holding register with valid/ready backpressure.
// Handshake: a beat moves on a port at a rising edge iff valid && ready on that edge; valid never depends on ready.

module leaf_router_fifo #(
  parameter int W     = 22,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_push;
  logic         w_do_pop;

  // Extra pointer bit separates full from empty when the index bits match.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push && !reset) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end
endmodule

module leaf_router_buffered #(
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter int         NUM_SPINES = 4,
  parameter logic [3:0] GROUP_ID   = 4'b0001,
  parameter int         ROUTER_ID  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         arb_enable,
  input  logic [DWIDTH-1:0]            gpu_in_data,
  input  logic                         gpu_in_valid,
  output logic                         gpu_in_ready,
  input  logic [5:0]                   gpu_dest_addr,
  output logic [DWIDTH-1:0]            gpu_out_data,
  output logic                         gpu_out_valid,
  input  logic                         gpu_out_ready,
  input  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data,
  input  logic [NUM_SPINES-1:0]        spine_in_valid,
  output logic [NUM_SPINES-1:0]        spine_in_ready,
  input  logic [NUM_SPINES*6-1:0]      spine_dest_addr,
  output logic [NUM_SPINES*DWIDTH-1:0] spine_out_data,
  output logic [NUM_SPINES-1:0]        spine_out_valid,
  input  logic [NUM_SPINES-1:0]        spine_out_ready,
  output logic [NUM_SPINES-1:0]        spine_fifo_in_full,
  output logic [NUM_SPINES-1:0]        spine_fifo_in_empty,
  output logic                         gpu_fifo_in_full,
  output logic                         gpu_fifo_in_empty,
  output logic                         crossbar_busy,
  output logic [2:0]                   current_grant,
  output logic [1:0]                   routing_direction,
  output logic [7:0]                   drop_count
);
  localparam int         NR  = NUM_SPINES + 1;
  localparam int         EW  = DWIDTH + 6;
  localparam logic [1:0] RID = 2'(ROUTER_ID);

  function automatic logic is_local(input logic [5:0] d);
    return (d[5:2] == GROUP_ID) && (d[1:0] == RID);
  endfunction

  logic [EW-1:0]         w_gpu_head;
  logic                  w_gpu_local;
  logic                  w_gpu_pop;
  logic [1:0]            w_gpu_tgt;
  logic                  w_gpu_tgt_free;
  logic                  w_gpu_to_spine;
  logic [EW-1:0]         w_sp_head [NUM_SPINES];
  logic [NUM_SPINES-1:0] w_sp_local;
  logic [NUM_SPINES-1:0] w_sp_free;
  logic [NUM_SPINES-1:0] w_sp_drop;
  logic [NUM_SPINES-1:0] w_sp_pop;
  logic [NUM_SPINES-1:0] w_sp_load;
  logic [NR-1:0]         w_req;
  logic                  w_found;
  logic [2:0]            w_winner;
  logic                  w_gpu_load;
  logic [DWIDTH-1:0]     w_gpu_load_data;
  logic [8:0]            w_drop_sum;
  logic [7:0]            w_drop_next;

  logic                  r_gpu_valid;
  logic [DWIDTH-1:0]     r_gpu_data;
  logic [2:0]            r_ptr;
  logic [2:0]            r_grant;
  logic [1:0]            r_dir;
  logic [7:0]            r_drop;

  leaf_router_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_gpu_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (gpu_in_valid),
    .i_data  ({gpu_dest_addr, gpu_in_data}),
    .i_pop   (w_gpu_pop),
    .o_head  (w_gpu_head),
    .o_full  (gpu_fifo_in_full),
    .o_empty (gpu_fifo_in_empty)
  );

  assign gpu_in_ready = !gpu_fifo_in_full;
  assign w_gpu_local  = is_local(w_gpu_head[EW-1:DWIDTH]);
  // Spine index is the low dest bits; the mask collapses to spine 0 when there is one link.
  assign w_gpu_tgt    = w_gpu_head[DWIDTH+1:DWIDTH] & 2'(NUM_SPINES - 1);

  for (genvar g = 0; g < NUM_SPINES; g++) begin : g_spine
    logic              r_valid;
    logic [DWIDTH-1:0] r_data;

    leaf_router_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (spine_in_valid[g]),
      .i_data  ({spine_dest_addr[g*6 +: 6], spine_in_data[g*DWIDTH +: DWIDTH]}),
      .i_pop   (w_sp_pop[g]),
      .o_head  (w_sp_head[g]),
      .o_full  (spine_fifo_in_full[g]),
      .o_empty (spine_fifo_in_empty[g])
    );

    assign spine_in_ready[g] = !spine_fifo_in_full[g];
    assign w_sp_local[g]     = is_local(w_sp_head[g][EW-1:DWIDTH]);
    assign w_sp_free[g]      = !r_valid || spine_out_ready[g];
    // Misrouted spine traffic has no egress; it is discarded whenever transfers are enabled.
    assign w_sp_drop[g]      = arb_enable && !spine_fifo_in_empty[g] && !w_sp_local[g];
    assign w_sp_pop[g]       = w_sp_drop[g] || (w_gpu_load && (w_winner == 3'(g + 1)));
    assign w_sp_load[g]      = w_gpu_to_spine && (w_gpu_tgt == 2'(g));

    assign spine_out_valid[g]                   = r_valid;
    assign spine_out_data[g*DWIDTH +: DWIDTH]   = r_data;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (w_sp_load[g]) begin
        r_valid <= 1'b1;
        r_data  <= w_gpu_head[DWIDTH-1:0];
      end else if (spine_out_ready[g]) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_gpu_tgt_free = 1'b0;
    for (int i = 0; i < NUM_SPINES; i++) begin
      if (w_gpu_tgt == 2'(i)) w_gpu_tgt_free = w_sp_free[i];
    end
  end

  assign w_gpu_to_spine = arb_enable && !gpu_fifo_in_empty && !w_gpu_local && w_gpu_tgt_free;

  always_comb begin
    w_req    = '0;
    w_req[0] = !gpu_fifo_in_empty && w_gpu_local;
    for (int i = 0; i < NUM_SPINES; i++) begin
      w_req[i+1] = !spine_fifo_in_empty[i] && w_sp_local[i];
    end
  end

  // Round robin: first requester at or above the pointer, otherwise the lowest one below it.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int j = 0; j < NR; j++) begin
      if (!w_found && w_req[j] && (j >= int'(r_ptr))) begin
        w_found  = 1'b1;
        w_winner = 3'(j);
      end
    end
    for (int j = 0; j < NR; j++) begin
      if (!w_found && w_req[j]) begin
        w_found  = 1'b1;
        w_winner = 3'(j);
      end
    end
  end

  assign w_gpu_load = arb_enable && (!r_gpu_valid || gpu_out_ready) && w_found;
  assign w_gpu_pop  = (w_gpu_load && (w_winner == 3'd0)) || w_gpu_to_spine;

  always_comb begin
    w_gpu_load_data = w_gpu_head[DWIDTH-1:0];
    for (int i = 0; i < NUM_SPINES; i++) begin
      if (w_winner == 3'(i + 1)) w_gpu_load_data = w_sp_head[i][DWIDTH-1:0];
    end
  end

  always_comb begin
    w_drop_sum = {1'b0, r_drop};
    for (int i = 0; i < NUM_SPINES; i++) begin
      w_drop_sum = w_drop_sum + 9'(w_sp_drop[i]);
    end
  end

  assign w_drop_next = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpu_valid <= 1'b0;
      r_gpu_data  <= '0;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_dir       <= 2'b00;
      r_drop      <= '0;
    end else begin
      if (w_gpu_load) begin
        r_gpu_valid <= 1'b1;
        r_gpu_data  <= w_gpu_load_data;
        r_grant     <= w_winner;
        r_ptr       <= (w_winner == 3'(NUM_SPINES)) ? 3'd0 : w_winner + 3'd1;
      end else if (gpu_out_ready) begin
        r_gpu_valid <= 1'b0;
      end
      r_dir  <= {w_gpu_load, w_gpu_to_spine};
      r_drop <= w_drop_next;
    end
  end

  assign gpu_out_valid     = r_gpu_valid;
  assign gpu_out_data      = r_gpu_data;
  assign current_grant     = r_grant;
  assign routing_direction = r_dir;
  assign drop_count        = r_drop;
  assign crossbar_busy     = !gpu_fifo_in_empty || !(&spine_fifo_in_empty)
                             || r_gpu_valid || (|spine_out_valid);
endmodule

// File: tb/tb_leaf_router_buffered.sv
// Bench for leaf_router_buffered: scenario tasks plus a scoreboard monitor on both egress sides.
module tb_leaf_router_buffered;
  localparam int DW = 16;
  localparam int NS = 4;
  localparam logic [5:0] LOCAL_DEST = {4'b0001, 2'd3};

  logic           clk = 1'b0;
  logic           reset;
  logic           arb_enable;
  logic [DW-1:0]  gpu_in_data;
  logic           gpu_in_valid;
  logic           gpu_in_ready;
  logic [5:0]     gpu_dest_addr;
  logic [DW-1:0]  gpu_out_data;
  logic           gpu_out_valid;
  logic           gpu_out_ready;
  logic [NS*DW-1:0] spine_in_data;
  logic [NS-1:0]  spine_in_valid;
  logic [NS-1:0]  spine_in_ready;
  logic [NS*6-1:0] spine_dest_addr;
  logic [NS*DW-1:0] spine_out_data;
  logic [NS-1:0]  spine_out_valid;
  logic [NS-1:0]  spine_out_ready;
  logic [NS-1:0]  spine_fifo_in_full;
  logic [NS-1:0]  spine_fifo_in_empty;
  logic           gpu_fifo_in_full;
  logic           gpu_fifo_in_empty;
  logic           crossbar_busy;
  logic [2:0]     current_grant;
  logic [1:0]     routing_direction;
  logic [7:0]     drop_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] gpu_exp_q[$];
  logic [DW+1:0] sp_exp_q[$];
  logic [DW-1:0] m_exp;
  logic [DW+1:0] m_sp_exp;

  leaf_router_buffered dut (
    .clk(clk), .reset(reset), .arb_enable(arb_enable),
    .gpu_in_data(gpu_in_data), .gpu_in_valid(gpu_in_valid), .gpu_in_ready(gpu_in_ready),
    .gpu_dest_addr(gpu_dest_addr),
    .gpu_out_data(gpu_out_data), .gpu_out_valid(gpu_out_valid), .gpu_out_ready(gpu_out_ready),
    .spine_in_data(spine_in_data), .spine_in_valid(spine_in_valid), .spine_in_ready(spine_in_ready),
    .spine_dest_addr(spine_dest_addr),
    .spine_out_data(spine_out_data), .spine_out_valid(spine_out_valid), .spine_out_ready(spine_out_ready),
    .spine_fifo_in_full(spine_fifo_in_full), .spine_fifo_in_empty(spine_fifo_in_empty),
    .gpu_fifo_in_full(gpu_fifo_in_full), .gpu_fifo_in_empty(gpu_fifo_in_empty),
    .crossbar_busy(crossbar_busy), .current_grant(current_grant),
    .routing_direction(routing_direction), .drop_count(drop_count)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every completed egress handshake must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (gpu_out_valid && gpu_out_ready) begin
        checks++;
        if (gpu_exp_q.size() == 0) begin
          errors++;
          $display("FAIL gpu_out_unexpected got=%h expected=none", gpu_out_data);
        end else begin
          m_exp = gpu_exp_q.pop_front();
          if (gpu_out_data !== m_exp) begin
            errors++;
            $display("FAIL gpu_out_data got=%h expected=%h", gpu_out_data, m_exp);
          end
        end
      end
      for (int i = 0; i < NS; i++) begin
        if (spine_out_valid[i] && spine_out_ready[i]) begin
          checks++;
          if (sp_exp_q.size() == 0) begin
            errors++;
            $display("FAIL spine_out_unexpected spine=%0d got=%h expected=none", i, spine_out_data[i*DW +: DW]);
          end else begin
            m_sp_exp = sp_exp_q.pop_front();
            if ({2'(i), spine_out_data[i*DW +: DW]} !== m_sp_exp) begin
              errors++;
              $display("FAIL spine_out got=%0d:%h expected=%0d:%h", i, spine_out_data[i*DW +: DW],
                       m_sp_exp[DW+1:DW], m_sp_exp[DW-1:0]);
            end
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    gpu_in_valid   = 1'b0;
    gpu_in_data    = '0;
    gpu_dest_addr  = '0;
    spine_in_valid = '0;
    spine_in_data  = '0;
    spine_dest_addr = '0;
  endtask

  task automatic push_gpu(input logic [DW-1:0] d, input logic [5:0] dest);
    gpu_in_valid  = 1'b1;
    gpu_in_data   = d;
    gpu_dest_addr = dest;
    step();
    gpu_in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    arb_enable = 1'b1;
    gpu_out_ready = 1'b1;
    spine_out_ready = '1;
    idle_inputs();
    repeat (3) step();
    reset = 1'b0;
    step();
    checks++;
    if ({gpu_out_valid, spine_out_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_valids got=%b expected=00000", {gpu_out_valid, spine_out_valid});
    end
    checks++;
    if ({gpu_out_data, spine_out_data} !== '0) begin
      errors++; $display("FAIL reset_data got=%h expected=0", {gpu_out_data, spine_out_data});
    end
    checks++;
    if ({gpu_in_ready, spine_in_ready} !== 5'b11111) begin
      errors++; $display("FAIL reset_in_ready got=%b expected=11111", {gpu_in_ready, spine_in_ready});
    end
    checks++;
    if ({current_grant, routing_direction, drop_count} !== 13'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%b/%0d expected=0/00/0", current_grant, routing_direction, drop_count);
    end
    checks++;
    if ({gpu_fifo_in_empty, spine_fifo_in_empty, crossbar_busy} !== 6'b111110) begin
      errors++; $display("FAIL reset_empty_busy got=%b expected=111110", {gpu_fifo_in_empty, spine_fifo_in_empty, crossbar_busy});
    end
  endtask

  task automatic test_loopback();
    gpu_exp_q.push_back(16'hA5A5);
    push_gpu(16'hA5A5, LOCAL_DEST);
    checks++;
    if (gpu_out_valid !== 1'b0) begin
      errors++; $display("FAIL loopback_latency got=%b expected=0", gpu_out_valid);
    end
    step();
    checks++;
    if (gpu_out_valid !== 1'b1 || gpu_out_data !== 16'hA5A5) begin
      errors++; $display("FAIL loopback_out got=%b/%h expected=1/a5a5", gpu_out_valid, gpu_out_data);
    end
    checks++;
    if (routing_direction !== 2'b10 || current_grant !== 3'd0) begin
      errors++; $display("FAIL loopback_dir_grant got=%b/%0d expected=10/0", routing_direction, current_grant);
    end
    repeat (2) step();
  endtask

  task automatic test_gpu_to_spine();
    logic [DW-1:0] d;
    d = 16'(($urandom_range(0, 65535)));
    sp_exp_q.push_back({2'd1, d});
    push_gpu(d, 6'b1000_01);
    step();
    checks++;
    if (spine_out_valid !== 4'b0010 || spine_out_data[DW +: DW] !== d) begin
      errors++; $display("FAIL to_spine_out got=%b/%h expected=0010/%h", spine_out_valid, spine_out_data[DW +: DW], d);
    end
    checks++;
    if (routing_direction !== 2'b01 || gpu_out_valid !== 1'b0) begin
      errors++; $display("FAIL to_spine_dir got=%b/%b expected=01/0", routing_direction, gpu_out_valid);
    end
    repeat (2) step();
  endtask

  task automatic test_spine_round_robin();
    for (int i = 0; i < NS; i++) begin
      spine_in_data[i*DW +: DW] = 16'h1000 + 16'(i);
      spine_dest_addr[i*6 +: 6] = LOCAL_DEST;
      gpu_exp_q.push_back(16'h1000 + 16'(i));
    end
    spine_in_valid = '1;
    step();
    spine_in_valid = '0;
    for (int k = 1; k <= NS; k++) begin
      step();
      checks++;
      if (current_grant !== 3'(k) || gpu_out_data !== 16'h1000 + 16'(k - 1)) begin
        errors++; $display("FAIL rr_grant got=%0d/%h expected=%0d/%h", current_grant, gpu_out_data, k, 16'h1000 + 16'(k - 1));
      end
    end
    step();
    // Pointer has wrapped to 0: GPU loopback must beat spine 0 when both request.
    gpu_exp_q.push_back(16'hB000);
    gpu_exp_q.push_back(16'hB001);
    spine_in_valid[0] = 1'b1;
    spine_in_data[0 +: DW] = 16'hB001;
    spine_dest_addr[0 +: 6] = LOCAL_DEST;
    push_gpu(16'hB000, LOCAL_DEST);
    spine_in_valid = '0;
    step();
    checks++;
    if (current_grant !== 3'd0 || gpu_out_data !== 16'hB000) begin
      errors++; $display("FAIL rr_wrap_first got=%0d/%h expected=0/b000", current_grant, gpu_out_data);
    end
    step();
    checks++;
    if (current_grant !== 3'd1 || gpu_out_data !== 16'hB001) begin
      errors++; $display("FAIL rr_wrap_second got=%0d/%h expected=1/b001", current_grant, gpu_out_data);
    end
    repeat (2) step();
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted = 0;
    gpu_out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      gpu_in_valid  = 1'b1;
      gpu_in_data   = 16'hC000 + 16'(k);
      gpu_dest_addr = LOCAL_DEST;
      if (gpu_in_ready) begin
        accepted++;
        gpu_exp_q.push_back(16'hC000 + 16'(k));
      end
      step();
    end
    gpu_in_valid = 1'b0;
    checks++;
    if (accepted != 9) begin
      errors++; $display("FAIL bp_accepted got=%0d expected=9", accepted);
    end
    checks++;
    if (gpu_in_ready !== 1'b0 || gpu_fifo_in_full !== 1'b1) begin
      errors++; $display("FAIL bp_full got=%b/%b expected=0/1", gpu_in_ready, gpu_fifo_in_full);
    end
    repeat (3) step();
    checks++;
    if (gpu_out_valid !== 1'b1 || gpu_out_data !== 16'hC000) begin
      errors++; $display("FAIL bp_hold got=%b/%h expected=1/c000", gpu_out_valid, gpu_out_data);
    end
    gpu_out_ready = 1'b1;
    for (int t = 0; t < 40 && gpu_exp_q.size() != 0; t++) step();
    checks++;
    if (gpu_exp_q.size() != 0) begin
      errors++; $display("FAIL bp_drain remaining=%0d expected=0", gpu_exp_q.size());
    end
    repeat (2) step();
  endtask

  task automatic test_drop();
    spine_in_valid[2] = 1'b1;
    spine_dest_addr[12 +: 6] = {4'b0010, 2'd0};
    for (int k = 0; k < 3; k++) begin
      spine_in_data[2*DW +: DW] = 16'($urandom_range(0, 65535));
      step();
    end
    spine_in_valid = '0;
    repeat (2) step();
    checks++;
    if (drop_count !== 8'd3 || gpu_out_valid !== 1'b0) begin
      errors++; $display("FAIL drop_three got=%0d/%b expected=3/0", drop_count, gpu_out_valid);
    end
    arb_enable = 1'b0;
    spine_in_valid[2] = 1'b1;
    step();
    spine_in_valid = '0;
    repeat (2) step();
    checks++;
    if (drop_count !== 8'd3 || spine_fifo_in_empty[2] !== 1'b0 || crossbar_busy !== 1'b1) begin
      errors++; $display("FAIL drop_disabled got=%0d/%b/%b expected=3/0/1", drop_count, spine_fifo_in_empty[2], crossbar_busy);
    end
    arb_enable = 1'b1;
    step();
    checks++;
    if (drop_count !== 8'd4) begin
      errors++; $display("FAIL drop_reenabled got=%0d expected=4", drop_count);
    end
    spine_in_valid[2] = 1'b1;
    repeat (300) step();
    spine_in_valid = '0;
    repeat (2) step();
    checks++;
    if (drop_count !== 8'd255) begin
      errors++; $display("FAIL drop_saturate got=%0d expected=255", drop_count);
    end
  endtask

  task automatic test_reset_flush();
    int seen;
    seen = 0;
    arb_enable = 1'b0;
    for (int k = 0; k < 5; k++) push_gpu(16'hD000 + 16'(k), LOCAL_DEST);
    checks++;
    if (gpu_fifo_in_empty !== 1'b0 || gpu_out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_filled got=%b/%b expected=0/0", gpu_fifo_in_empty, gpu_out_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({gpu_out_valid, spine_out_valid} !== 5'b0 || gpu_fifo_in_empty !== 1'b1 || drop_count !== 8'd0) begin
      errors++; $display("FAIL flush_state got=%b/%b/%0d expected=00000/1/0", {gpu_out_valid, spine_out_valid}, gpu_fifo_in_empty, drop_count);
    end
    arb_enable = 1'b1;
    gpu_out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (gpu_out_valid) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_stale got=%0d expected=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_gpu_to_spine();
    test_spine_round_robin();
    test_backpressure();
    test_drop();
    test_reset_flush();
    checks++;
    if (gpu_exp_q.size() != 0 || sp_exp_q.size() != 0) begin
      errors++; $display("FAIL final_queues got=%0d/%0d expected=0/0", gpu_exp_q.size(), sp_exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
